// File: rtl/alu_issue_stage.sv
// Operand-issue and writeback stage in front of a combinational 32-bit ALU.
// Owns the register file, forwards the in-flight result and latches the Z/S flags.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int AW     = 4,
    parameter int IMM_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hold,
    input  logic [AW-1:0]     in_rs,
    input  logic [AW-1:0]     in_rt,
    input  logic [AW-1:0]     in_rd,
    input  logic [3:0]        in_funct,
    input  logic              in_use_imm,
    input  logic [IMM_W-1:0]  in_imm,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [3:0]        alu_funct,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_flagZ,
    input  logic              alu_flagS,
    output logic              wb_valid,
    output logic [AW-1:0]     wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_Z,
    output logic              flag_S,
    output logic              err_illegal,
    input  logic [AW-1:0]     dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0001;
    localparam logic [3:0] FN_AND = 4'b0010;
    localparam logic [3:0] FN_OR  = 4'b0011;
    localparam logic [3:0] FN_XOR = 4'b0100;
    localparam logic [3:0] FN_SLA = 4'b0110;
    localparam logic [3:0] FN_SRA = 4'b0111;
    localparam logic [3:0] FN_SRL = 4'b1000;

    logic [DATA_W-1:0] rf_reg [NREGS];
    logic              ex_valid_reg;
    logic [AW-1:0]     ex_rd_reg;

    logic              fire;
    logic              funct_legal;
    logic              wb_en;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] opa_next;
    logic [DATA_W-1:0] opb_next;

    assign in_ready = ~hold;
    assign fire     = in_valid & ~hold;
    assign wb_en    = ex_valid_reg & ~hold;
    assign imm_ext  = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

    always_comb begin
        funct_legal = 1'b0;
        case (in_funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR,
            FN_XOR, FN_SLA, FN_SRA, FN_SRL: funct_legal = 1'b1;
            default:                        funct_legal = 1'b0;
        endcase
    end

    // Source read: r0 is hard zero, then the result completing on this edge, then the file.
    always_comb begin
        opa_next = '0;
        opb_next = '0;
        if (in_rs != '0) begin
            if (ex_valid_reg && (ex_rd_reg == in_rs))
                opa_next = alu_out;
            else
                opa_next = rf_reg[in_rs];
        end
        if (in_use_imm) begin
            opb_next = imm_ext;
        end else if (in_rt != '0) begin
            if (ex_valid_reg && (ex_rd_reg == in_rt))
                opb_next = alu_out;
            else
                opb_next = rf_reg[in_rt];
        end
    end

    // Register file; entry 0 never takes a write so it stays at its reset value of zero.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    rf_reg[gi] <= '0;
                else if (wb_en && (gi != 0) && (ex_rd_reg == AW'(gi)))
                    rf_reg[gi] <= alu_out;
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid_reg <= 1'b0;
            ex_rd_reg    <= '0;
            alu_A        <= '0;
            alu_B        <= '0;
            alu_funct    <= '0;
            err_illegal  <= 1'b0;
        end else if (hold) begin
            err_illegal  <= 1'b0;
        end else begin
            ex_valid_reg <= fire & funct_legal;
            err_illegal  <= fire & ~funct_legal;
            if (fire && funct_legal) begin
                alu_A     <= opa_next;
                alu_B     <= opb_next;
                alu_funct <= in_funct;
                ex_rd_reg <= in_rd;
            end
        end
    end

    // Flags follow every completed operation, including rd=0 compares.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            flag_Z   <= 1'b0;
            flag_S   <= 1'b0;
        end else begin
            wb_valid <= wb_en;
            if (wb_en) begin
                wb_rd   <= ex_rd_reg;
                wb_data <= alu_out;
                flag_Z  <= alu_flagZ;
                flag_S  <= alu_flagS;
            end
        end
    end

    assign dbg_rdata = (dbg_raddr == '0) ? '0 : rf_reg[dbg_raddr];

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue and writeback stage directly upstream of the 32-bit ALU (funct-coded ADD/SUB/AND/OR/XOR/SLA/SRA/SRL, flags Z/S).
- Holds a 16x32 register file, accepts one instruction per cycle over a valid/ready handshake, and drives registered A/B/funct into the ALU.
- Writes the ALU result back one cycle after issue and latches the Z/S flags.
- Forwards in-flight results so back-to-back dependent instructions issue without stalls.

Parameters:
DATA_W, 32, datapath width (ALU A/B/out width)
NREGS, 16, number of architectural registers; r0 reads as zero
AW, 4, register address width (log2 NREGS)
IMM_W, 16, immediate width, sign-extended to DATA_W

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  instruction present
in_ready  out  1  stage can accept; = ~hold
hold  in  1  freeze: no issue, no writeback, pipeline state held
in_rs  in  AW  source A register
in_rt  in  AW  source B register (ignored when in_use_imm=1)
in_rd  in  AW  destination register
in_funct  in  4  ALU operation code
in_use_imm  in  1  B = sign-extended in_imm instead of reg[in_rt]
in_imm  in  IMM_W  immediate
alu_A  out  DATA_W  registered operand A to ALU
alu_B  out  DATA_W  registered operand B to ALU
alu_funct  out  4  registered funct to ALU
alu_out  in  DATA_W  ALU combinational result
alu_flagZ  in  1  ALU zero flag
alu_flagS  in  1  ALU sign flag
wb_valid  out  1  pulses the cycle after a result is written
wb_rd  out  AW  register written
wb_data  out  DATA_W  value written
flag_Z  out  1  latched zero flag
flag_S  out  1  latched sign flag
err_illegal  out  1  one-cycle pulse: illegal funct dropped
dbg_raddr  in  AW  debug read address
dbg_rdata  out  DATA_W  combinational reg[dbg_raddr] (r0 = 0)

Behaviour:
- Reset (async, immediate): all registers, alu_A, alu_B, alu_funct, ex_valid, ex_rd, wb_valid, wb_rd, wb_data, flag_Z, flag_S, err_illegal = 0.
- Legal funct codes: 0000, 0001, 0010, 0011, 0100, 0110, 0111, 1000. All others are illegal.
- Issue: fires on a rising edge when in_valid & in_ready.
  - Legal funct: latch alu_A, alu_B, alu_funct, ex_rd; set ex_valid=1.
  - Illegal funct: ex_valid=0 (bubble); err_illegal=1 for one cycle; alu_* unchanged.
  - No fire and hold=0: ex_valid=0; alu_* unchanged.
- Operand read, combinational before the issue edge, priority order:
  1. r0 reads 0.
  2. If ex_valid & ex_rd==src & ex_rd!=0, forward alu_out.
  3. Otherwise reg[src].
  - in_use_imm=1: B = sign-extended in_imm.
- Writeback: on any edge with ex_valid=1 and hold=0:
  - reg[ex_rd] <= alu_out, except when ex_rd==0 (no write).
  - flag_Z <= alu_flagZ and flag_S <= alu_flagS. Flags update even when rd=0 (compare idiom).
  - wb_valid <= 1, wb_rd <= ex_rd, wb_data <= alu_out. Otherwise wb_valid <= 0.
- Latency: issue at edge k; ALU sees operands after edge k; result is in the register file and wb_valid=1 after edge k+1. Throughput is 1 per cycle.
- Hold=1: in_ready=0. ex_valid, alu_*, registers and flags are frozen. wb_valid and err_illegal drop to 0 after the next edge. On release the held instruction writes back normally.
- Simultaneous events: the issuing instruction reads the forwarded value of the writeback completing on the same edge (rule 2), never the stale register.
- Reset mid-operation: the in-flight instruction is discarded and no write occurs.
- Shift amounts and arithmetic are the ALU's concern; this stage passes operands unmodified.

Test Plan:
- Reset then dbg read r0..r15 -> all 0; flag_Z=0, flag_S=0, wb_valid=0, in_ready=1.
- Issue ADD r1=r0+imm 5, then ADD r2=r0+imm 7, then ADD r3=r1+r2 on consecutive cycles -> third issue sees alu_A=5 (from register file) and alu_B=7 (forwarded); r3=12, wb_valid one cycle after each issue.
- Issue SUB r4=r0+imm(-10)... i.e. ADD r4=r0+imm 0xFFF6, then SUB r5=r4-imm 5 -> r5=0xFFFFFFF1, flag_S=1, flag_Z=0.
- XOR r6=r1^r1 with rd=0 variant -> r0 stays 0, flag_Z=1; repeat with rd=6 -> r6=0, flag_Z=1.
- Issue funct=0101 -> err_illegal pulses once, no wb_valid, registers unchanged, next legal instruction proceeds.
- Hold asserted 3 cycles right after an issue -> in_ready=0, no write until hold drops, then exactly one write. Assert reset mid-flight -> no write, all outputs 0 immediately.
